// File: rtl/uart_frame_loader_if.sv
// uart_frame_loader_if: byte stream in, buffer write port and frame handshake out.
// Ports (master = loader side):
//   rx_vld/rx_data  - byte strobe and data from the UART receiver
//   frame_ack       - engine consumed the held frame
//   wr_en/wr_addr/wr_data - image buffer write port
//   frame_rdy/frame_len   - held frame valid level and its payload length
//   frame_err       - one-cycle error pulse
//   busy            - loader is inside a frame
interface uart_frame_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_vld;
    logic [7:0]        rx_data;
    logic              frame_ack;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_rdy;
    logic [ADDR_W:0]   frame_len;
    logic              frame_err;
    logic              busy;

    modport master (
        input  rx_vld, rx_data, frame_ack,
        output wr_en, wr_addr, wr_data, frame_rdy, frame_len, frame_err, busy
    );

    modport slave (
        output rx_vld, rx_data, frame_ack,
        input  wr_en, wr_addr, wr_data, frame_rdy, frame_len, frame_err, busy
    );
endinterface

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: frames UART bytes (header, 16-bit length, payload, checksum) into the image buffer.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - uart_frame_loader_if.master: UART byte input, buffer write port, frame handshake
module uart_frame_loader #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int          ADDR_W      = 10,
    parameter logic [16:0] TIMEOUT_CNT = 17'd86700
) (
    input  logic               clk,
    input  logic               rst,
    uart_frame_loader_if.master bus
);
    localparam int          CW      = ADDR_W + 1;
    localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {S_HUNT, S_LEN_L, S_LEN_H, S_DATA, S_CSUM, S_HOLD} state_t;

    state_t            state, state_n;
    logic [7:0]        len_lo, len_lo_n;
    logic [CW-1:0]     len_q, len_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [7:0]        csum, csum_n;
    logic [16:0]       tmo, tmo_n;
    logic              wr_en_q, wr_en_n;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
    logic [7:0]        wr_data_q, wr_data_n;
    logic              rdy_q, rdy_n;
    logic [CW-1:0]     flen_q, flen_n;
    logic              err_q, err_n;
    logic              busy_q;
    logic [15:0]       len_full;
    logic              active;

    assign len_full = {bus.rx_data, len_lo};
    assign active   = state inside {S_LEN_L, S_LEN_H, S_DATA, S_CSUM};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_HUNT;
            len_lo    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            csum      <= '0;
            tmo       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rdy_q     <= 1'b0;
            flen_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            len_lo    <= len_lo_n;
            len_q     <= len_n;
            cnt       <= cnt_n;
            csum      <= csum_n;
            tmo       <= tmo_n;
            wr_en_q   <= wr_en_n;
            wr_addr_q <= wr_addr_n;
            wr_data_q <= wr_data_n;
            rdy_q     <= rdy_n;
            flen_q    <= flen_n;
            err_q     <= err_n;
            busy_q    <= state_n != S_HUNT;
        end
    end

    always_comb begin
        state_n   = state;
        len_lo_n  = len_lo;
        len_n     = len_q;
        cnt_n     = cnt;
        csum_n    = csum;
        tmo_n     = '0;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_q;
        wr_data_n = wr_data_q;
        rdy_n     = rdy_q;
        flen_n    = flen_q;
        err_n     = 1'b0;
        // An accepted byte always wins over the terminal count, so the gap timer only advances on idle cycles.
        if (active && !bus.rx_vld) begin
            if (tmo == TIMEOUT_CNT - 17'd1) begin
                err_n   = 1'b1;
                state_n = S_HUNT;
            end else begin
                tmo_n = tmo + 17'd1;
            end
        end
        case (state)
            S_HUNT:
                if (bus.rx_vld && bus.rx_data == HEADER) state_n = S_LEN_L;
            S_LEN_L:
                if (bus.rx_vld) begin
                    len_lo_n = bus.rx_data;
                    state_n  = S_LEN_H;
                end
            S_LEN_H:
                if (bus.rx_vld) begin
                    if (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN) begin
                        err_n   = 1'b1;
                        state_n = S_HUNT;
                    end else begin
                        len_n   = len_full[CW-1:0];
                        cnt_n   = '0;
                        csum_n  = '0;
                        state_n = S_DATA;
                    end
                end
            S_DATA:
                if (bus.rx_vld) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = cnt[ADDR_W-1:0];
                    wr_data_n = bus.rx_data;
                    csum_n    = csum + bus.rx_data;
                    cnt_n     = cnt + CW'(1);
                    if (cnt + CW'(1) == len_q) state_n = S_CSUM;
                end
            S_CSUM:
                if (bus.rx_vld) begin
                    if (bus.rx_data == csum) begin
                        flen_n  = len_q;
                        rdy_n   = 1'b1;
                        state_n = S_HOLD;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_HUNT;
                    end
                end
            S_HOLD:
                if (bus.frame_ack) begin
                    rdy_n   = 1'b0;
                    state_n = S_HUNT;
                end
            default: state_n = S_HUNT;
        endcase
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.frame_rdy = rdy_q;
    assign bus.frame_len = flen_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader: scoreboard bench for uart_frame_loader (short timeout to keep the run small).
module tb_uart_frame_loader;
    localparam int          AW  = 10;
    localparam logic [16:0] TMO = 17'd300;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    int err_seen = 0;
    logic [AW+7:0] exp_q[$];

    uart_frame_loader_if #(.ADDR_W(AW)) bus();

    uart_frame_loader #(.HEADER(8'hA5), .ADDR_W(AW), .TIMEOUT_CNT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Every write is popped against the expectations pushed when its byte was sent.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected got addr=%0d data=%h want none", bus.wr_addr, bus.wr_data);
            end else begin
                logic [AW+7:0] e;
                e = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== e) begin
                    bad++;
                    $display("FAIL wr_match got addr=%0d data=%h want addr=%0d data=%h",
                             bus.wr_addr, bus.wr_data, e[AW+7:8], e[7:0]);
                end
            end
        end
        if (bus.frame_err) err_seen++;
    end

    task automatic push(input int a, input logic [7:0] d);
        exp_q.push_back({AW'(a), d});
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_vld = 1'b1;
        bus.rx_data = b;
        @(posedge clk); #1;
        bus.rx_vld = 1'b0;
    endtask

    task automatic ack();
        @(posedge clk); #1;
        bus.frame_ack = 1'b1;
        @(posedge clk); #1;
        bus.frame_ack = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        logic [AW+7+1+AW+1+1+1+1:0] all;
        bus.rx_vld = 1'b0;
        bus.rx_data = 8'h00;
        bus.frame_ack = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        all = {bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_rdy, bus.frame_len, bus.frame_err, bus.busy};
        total++;
        if (all !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", all);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_busy_after_release", int'(bus.busy), 0);
    endtask

    task automatic test_good_frame();
        push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44);
        send(8'hA5);
        chk("good_busy", int'(bus.busy), 1);
        send(8'h04); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("good_rdy_before_csum", int'(bus.frame_rdy), 0);
        send(8'hAA);
        chk("good_rdy", int'(bus.frame_rdy), 1);
        chk("good_len", int'(bus.frame_len), 4);
        chk("good_writes_done", exp_q.size(), 0);
        ack();
        chk("good_rdy_after_ack", int'(bus.frame_rdy), 0);
        chk("good_busy_after_ack", int'(bus.busy), 0);
    endtask

    task automatic test_bad_csum();
        push(0, 8'h10); push(1, 8'h20);
        send(8'hA5); send(8'h02); send(8'h00); send(8'h10); send(8'h20); send(8'h31);
        chk("csum_err", int'(bus.frame_err), 1);
        chk("csum_busy", int'(bus.busy), 0);
        chk("csum_rdy", int'(bus.frame_rdy), 0);
        @(posedge clk); #1;
        chk("csum_err_one_cycle", int'(bus.frame_err), 0);
    endtask

    task automatic test_bad_len();
        send(8'hA5); send(8'h00); send(8'h00);
        chk("len0_err", int'(bus.frame_err), 1);
        chk("len0_busy", int'(bus.busy), 0);
        send(8'hA5); send(8'h01); send(8'h04);
        chk("len1025_err", int'(bus.frame_err), 1);
        chk("len1025_busy", int'(bus.busy), 0);
        push(1023, 8'h5A);
        send(8'hA5); send(8'h00); send(8'h04);
        chk("len1024_ok", int'(bus.busy), 1);
        rst = 1'b0; #1; rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_timeout();
        int n;
        push(0, 8'h55);
        send(8'hA5); send(8'h03); send(8'h00); send(8'h55);
        n = 0;
        while (n < int'(TMO) + 20 && bus.frame_err !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_cycles", n, int'(TMO));
        chk("timeout_busy", int'(bus.busy), 0);
        push(0, 8'h66);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h66); send(8'h66);
        chk("after_timeout_rdy", int'(bus.frame_rdy), 1);
        chk("after_timeout_len", int'(bus.frame_len), 1);
    endtask

    task automatic test_hold_lockout();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h77); send(8'h77);
        chk("hold_rdy", int'(bus.frame_rdy), 1);
        chk("hold_len", int'(bus.frame_len), 1);
        ack();
        chk("hold_released", int'(bus.frame_rdy), 0);
    endtask

    task automatic test_back_to_back();
        push(0, 8'h01); push(1, 8'h02);
        send(8'hA5); send(8'h02); send(8'h00);
        ack();
        chk("ack_outside_hold_busy", int'(bus.busy), 1);
        send(8'h01); send(8'h02); send(8'h03);
        chk("b2b_rdy", int'(bus.frame_rdy), 1);
        chk("b2b_len", int'(bus.frame_len), 2);
        ack();
        // Length low byte lands exactly on the timer's terminal count.
        push(0, 8'h42);
        send(8'hA5);
        repeat (int'(TMO) - 2) @(posedge clk);
        #1;
        send(8'h01);
        chk("tc_race_no_err", int'(bus.frame_err), 0);
        chk("tc_race_busy", int'(bus.busy), 1);
        send(8'h00); send(8'h42); send(8'h42);
        chk("tc_race_rdy", int'(bus.frame_rdy), 1);
        ack();
    endtask

    task automatic test_garbage_reset();
        send(8'h00); send(8'hFF); send(8'hA4);
        chk("garbage_busy", int'(bus.busy), 0);
        push(0, 8'h12);
        send(8'hA5); send(8'h03); send(8'h00); send(8'h12);
        send(8'h34);
        rst = 1'b0;
        #1;
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_data", int'(bus.wr_data), 0);
        chk("rst_busy", int'(bus.busy), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        push(0, 8'h9C);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h9C); send(8'h9C);
        chk("post_rst_rdy", int'(bus.frame_rdy), 1);
        ack();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_timeout();
        test_hold_lockout();
        test_back_to_back();
        test_garbage_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("err_pulse_count", err_seen, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
